// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry constants and FSM state type for the text-mode
// pixel-row fetcher (50x30 characters of 16x20 pixels, 800x600 screen).
package vga_pkg;

    localparam int unsigned H_CHARS     = 50;  // characters per text row
    localparam int unsigned V_CHARS     = 30;  // text rows per frame
    localparam int unsigned GLYPH_LINES = 20;  // pixel lines per glyph
    localparam int unsigned TADDR_W     = 11;  // text RAM address width
    localparam int unsigned FADDR_W     = 13;  // font ROM address width
    localparam int unsigned COL_W       = 6;   // holds 0..H_CHARS
    localparam int unsigned ROW_W       = 5;   // holds 0..V_CHARS

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHAR = 2'd1,
        FONT = 2'd2,
        LOAD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/text_addr_gen.sv
// text_addr_gen: registered text RAM address = row*H_CHARS + col, built from
// shifts and adds (row*50 = row*32 + row*16 + row*2).
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          capture a new address this edge
//   i_row, i_col    character row / column of the word to fetch
//   o_addr          registered address
module text_addr_gen
    import vga_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [ROW_W-1:0]   i_row,
    input  logic [COL_W-1:0]   i_col,
    output logic [TADDR_W-1:0] o_addr
);

    logic [TADDR_W-1:0] w_row_ext;
    logic [TADDR_W-1:0] w_col_ext;
    logic [TADDR_W-1:0] w_sum;
    logic [TADDR_W-1:0] r_addr;

    assign w_row_ext = TADDR_W'(i_row);
    assign w_col_ext = TADDR_W'(i_col);
    assign w_sum     = (w_row_ext << 5) + (w_row_ext << 4) + (w_row_ext << 1) + w_col_ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= w_sum;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/vga_text_fetch.sv
// vga_text_fetch: produces the 16-bit pixel_row word shifted out by the VGA
// timing generator. Each newData / end_of_line strobe launches a
// CHAR -> FONT -> LOAD fetch (text RAM char code, then font ROM glyph line),
// staging the result one word ahead in next_row. A line start fetches word 0
// straight into pixel_row and then word 1 into next_row.
// Optional feature: define VGA_TEXT_CURSOR_EN for a blinking block cursor on
// glyph lines 18-19 (adds cursor_col / cursor_row inputs).
// Ports:
//   CLK_VGA, resetn            pixel clock, asynchronous active-low reset
//   newData/end_of_line/end_of_frame  timing generator strobes
//   line_number                glyph line 0..19
//   text_rd/text_addr/text_q   text RAM read port (1-cycle latency)
//   font_rd/font_addr/font_q   font ROM read port (1-cycle latency)
//   pixel_row                  word being displayed
//   underrun                   sticky: strobe seen while a fetch was busy
module vga_text_fetch
    import vga_pkg::*;
(
    input  logic               CLK_VGA,
    input  logic               resetn,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [5:0]         cursor_col,
    input  logic [4:0]         cursor_row,
`endif
    input  logic               newData,
    input  logic               end_of_line,
    input  logic               end_of_frame,
    input  logic [4:0]         line_number,
    output logic               text_rd,
    output logic [TADDR_W-1:0] text_addr,
    input  logic [7:0]         text_q,
    output logic               font_rd,
    output logic [FADDR_W-1:0] font_addr,
    input  logic [15:0]        font_q,
    output logic [15:0]        pixel_row,
    output logic               underrun
);

    fetch_state_t     r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_char_row;
    logic [4:0]       r_line;
    logic [15:0]      r_pixel_row;
    logic [15:0]      r_next_row;
    logic             r_text_rd;
    logic             r_font_rd;
    logic             r_underrun;
    logic             r_ls;     // current fetch is the first word of a line
    logic             r_shift;  // pixel_row <= next_row at FONT -> LOAD
    logic             r_skip;   // fetch is off-screen: no memory access
    logic             r_inv;    // invert the glyph line (cursor)

    logic             w_strobe;
    logic             w_line_strobe;
    logic             w_start;
    logic             w_second;
    logic             w_launch;
    logic [ROW_W-1:0] w_row_nxt;
    logic [COL_W-1:0] w_col_inc;
    logic [COL_W-1:0] w_fetch_col;
    logic             w_skip;
    logic             w_inv;
    logic [15:0]      w_glyph;

    assign w_strobe      = newData | end_of_line | end_of_frame;
    // end_of_frame is coincident with the last end_of_line; treat it as one
    assign w_line_strobe = end_of_line | end_of_frame;
    assign w_start       = (r_state == IDLE) && w_strobe;
    assign w_second      = (r_state == LOAD) && r_ls;
    assign w_launch      = w_start | w_second;

    always_comb begin
        w_row_nxt = r_char_row;
        if (end_of_frame) begin
            w_row_nxt = '0;
        end else if (end_of_line && (line_number == 5'(GLYPH_LINES - 1))
                     && (r_char_row < ROW_W'(V_CHARS))) begin
            w_row_nxt = r_char_row + 1'b1;
        end
    end

    assign w_col_inc = (r_col >= COL_W'(H_CHARS)) ? COL_W'(H_CHARS) : r_col + 1'b1;

    always_comb begin
        w_fetch_col = r_col;
        if (w_second) begin
            w_fetch_col = w_col_inc;
        end else if (w_line_strobe) begin
            w_fetch_col = '0;
        end
    end

    assign w_skip = (w_fetch_col >= COL_W'(H_CHARS)) || (w_row_nxt >= ROW_W'(V_CHARS));

`ifdef VGA_TEXT_CURSOR_EN
    logic [5:0] r_frame_cnt;

    always_ff @(posedge CLK_VGA or negedge resetn) begin
        if (!resetn) begin
            r_frame_cnt <= '0;
        end else if (end_of_frame) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign w_inv = r_frame_cnt[5] && (w_fetch_col == cursor_col) && (w_row_nxt == cursor_row)
                   && (line_number >= 5'(GLYPH_LINES - 2));
`else
    assign w_inv = 1'b0;
`endif

    assign w_glyph = r_skip ? '0 : (r_inv ? ~font_q : font_q);

    text_addr_gen u_addr (
        .i_clk   (CLK_VGA),
        .i_rst_n (resetn),
        .i_load  (w_launch && !w_skip),
        .i_row   (w_row_nxt),
        .i_col   (w_fetch_col),
        .o_addr  (text_addr)
    );

    always_ff @(posedge CLK_VGA or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_char_row  <= '0;
            r_line      <= '0;
            r_pixel_row <= '0;
            r_next_row  <= '0;
            r_text_rd   <= 1'b0;
            r_font_rd   <= 1'b0;
            r_underrun  <= 1'b0;
            r_ls        <= 1'b0;
            r_shift     <= 1'b0;
            r_skip      <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            r_char_row <= w_row_nxt;
            if (w_strobe && (r_state != IDLE)) begin
                r_underrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_strobe) begin
                        r_state   <= CHAR;
                        r_ls      <= w_line_strobe;
                        r_shift   <= !w_line_strobe;
                        r_line    <= line_number;
                        r_skip    <= w_skip;
                        r_inv     <= w_inv;
                        r_text_rd <= !w_skip;
                        if (w_line_strobe) begin
                            r_col <= '0;
                        end
                    end
                end
                CHAR: begin
                    r_state   <= FONT;
                    r_text_rd <= 1'b0;
                    r_font_rd <= !r_skip;
                end
                FONT: begin
                    r_state   <= LOAD;
                    r_font_rd <= 1'b0;
                    if (r_shift) begin
                        r_pixel_row <= r_next_row;
                    end
                end
                LOAD: begin
                    r_col <= w_col_inc;
                    if (r_ls) begin
                        // line start: word 0 goes on screen now, word 1 follows
                        r_pixel_row <= w_glyph;
                        r_state     <= CHAR;
                        r_ls        <= 1'b0;
                        r_shift     <= 1'b0;
                        r_line      <= line_number;
                        r_skip      <= w_skip;
                        r_inv       <= w_inv;
                        r_text_rd   <= !w_skip;
                    end else begin
                        r_next_row <= w_glyph;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign text_rd   = r_text_rd;
    assign font_rd   = r_font_rd;
    assign font_addr = r_font_rd ? {text_q, r_line} : '0;
    assign pixel_row = r_pixel_row;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_vga_text_fetch.sv
module tb_vga_text_fetch;
    import vga_pkg::*;

    logic               CLK_VGA = 1'b0;
    logic               resetn = 1'b0;
    logic               newData = 1'b0;
    logic               end_of_line = 1'b0;
    logic               end_of_frame = 1'b0;
    logic [4:0]         line_number = '0;
    logic               text_rd;
    logic [TADDR_W-1:0] text_addr;
    logic [7:0]         text_q = '0;
    logic               font_rd;
    logic [FADDR_W-1:0] font_addr;
    logic [15:0]        font_q = '0;
    logic [15:0]        pixel_row;
    logic               underrun;
`ifdef VGA_TEXT_CURSOR_EN
    logic [5:0]         cursor_col = 6'd3;
    logic [4:0]         cursor_row = 5'd0;
`endif

    int checks = 0;
    int passed = 0;
    int n_rd = 0;
    int n_frd = 0;
    int unsigned max_addr = 0;
    int unsigned m_col;
    logic [15:0] m_next;
    logic [15:0] exp;

    logic [7:0]  tram [0:2047];
    logic [15:0] from [0:8191];

    always #5 CLK_VGA = ~CLK_VGA;

    vga_text_fetch dut (
        .CLK_VGA      (CLK_VGA),
        .resetn       (resetn),
`ifdef VGA_TEXT_CURSOR_EN
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
`endif
        .newData      (newData),
        .end_of_line  (end_of_line),
        .end_of_frame (end_of_frame),
        .line_number  (line_number),
        .text_rd      (text_rd),
        .text_addr    (text_addr),
        .text_q       (text_q),
        .font_rd      (font_rd),
        .font_addr    (font_addr),
        .font_q       (font_q),
        .pixel_row    (pixel_row),
        .underrun     (underrun)
    );

    // synchronous memories, one cycle read latency
    always @(posedge CLK_VGA) begin
        if (text_rd) text_q <= tram[text_addr];
        if (font_rd) font_q <= from[font_addr];
    end

    always @(negedge CLK_VGA) begin
        if (text_rd) begin
            n_rd++;
            if (int'(text_addr) > max_addr) max_addr = int'(text_addr);
        end
        if (font_rd) n_frd++;
    end

    function automatic logic [7:0] tchar(int unsigned a);
        return 8'(a + 65);
    endfunction

    function automatic logic [15:0] glyph(logic [7:0] c, logic [4:0] l);
        if (c == 8'h41 && l == 5'd0)  return 16'h0FF0;
        if (c == 8'h42 && l == 5'd0)  return 16'h1234;
        if (c == 8'h44 && l == 5'd18) return 16'h00FF;
        return {c, 3'b101, l};
    endfunction

    function automatic logic [15:0] word_at(int unsigned row, int unsigned col, logic [4:0] l);
        if (col >= 50 || row >= 30) return 16'h0000;
        return glyph(tchar(row * 50 + col), l);
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge CLK_VGA);
        #1;
    endtask

    // drive a one-cycle strobe; returns 1 time unit after the sampling edge
    task automatic pulse(logic nd, logic eol, logic eof, logic [4:0] ln);
        line_number  = ln;
        newData      = nd;
        end_of_line  = eol;
        end_of_frame = eof;
        @(posedge CLK_VGA);
        #1;
        newData      = 1'b0;
        end_of_line  = 1'b0;
        end_of_frame = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick(2);
        checks++; if (pixel_row !== 16'h0000) $display("FAIL reset_pixel_row: got %h want 0000", pixel_row); else passed++;
        checks++; if (text_rd !== 1'b0) $display("FAIL reset_text_rd: got %b want 0", text_rd); else passed++;
        checks++; if (font_rd !== 1'b0) $display("FAIL reset_font_rd: got %b want 0", font_rd); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
        checks++; if (text_addr !== 11'd0) $display("FAIL reset_text_addr: got %0d want 0", text_addr); else passed++;
        checks++; if (font_addr !== 13'd0) $display("FAIL reset_font_addr: got %h want 0", font_addr); else passed++;
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic test_line_start;
        pulse(1'b0, 1'b1, 1'b0, 5'd0);
        checks++; if (text_rd !== 1'b1) $display("FAIL ls_text_rd: got %b want 1", text_rd); else passed++;
        checks++; if (text_addr !== 11'd0) $display("FAIL ls_addr0: got %0d want 0", text_addr); else passed++;
        tick(2);
        checks++; if (pixel_row !== 16'h0000) $display("FAIL ls_early: got %h want 0000", pixel_row); else passed++;
        tick(1);
        checks++; if (pixel_row !== 16'h0FF0) $display("FAIL ls_pixel_e3: got %h want 0ff0", pixel_row); else passed++;
        checks++; if (text_rd !== 1'b1 || text_addr !== 11'd1)
            $display("FAIL ls_second_fetch: got rd=%b addr=%0d want rd=1 addr=1", text_rd, text_addr); else passed++;
        tick(4);
        m_col  = 2;
        m_next = 16'h1234;
    endtask

    task automatic test_newdata;
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        checks++; if (text_rd !== 1'b1 || text_addr !== 11'd2)
            $display("FAIL nd_addr: got rd=%b addr=%0d want rd=1 addr=2", text_rd, text_addr); else passed++;
        tick(1);
        checks++; if (pixel_row !== 16'h0FF0) $display("FAIL nd_before_e2: got %h want 0ff0", pixel_row); else passed++;
        checks++; if (font_rd !== 1'b1 || font_addr !== 13'h0860)
            $display("FAIL nd_font_addr: got rd=%b addr=%h want rd=1 addr=0860", font_rd, font_addr); else passed++;
        tick(1);
        checks++; if (pixel_row !== 16'h1234) $display("FAIL nd_pixel_e2: got %h want 1234", pixel_row); else passed++;
        tick(4);
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        checks++; if (text_addr !== 11'd3) $display("FAIL nd2_addr: got %0d want 3", text_addr); else passed++;
        tick(2);
        checks++; if (pixel_row !== 16'h43A0) $display("FAIL nd2_pixel: got %h want 43a0", pixel_row); else passed++;
        tick(4);
        m_col  = 4;
        m_next = 16'h44A0;
    endtask

    task automatic test_col_saturation;
        n_rd = 0; n_frd = 0; max_addr = 0;
        for (int k = 0; k < 50; k++) begin
            pulse(1'b1, 1'b0, 1'b0, 5'd0);
            tick(2);
            exp = m_next;
            checks++; if (pixel_row !== exp) $display("FAIL sat_pixel[%0d]: got %h want %h", k, pixel_row, exp); else passed++;
            m_next = word_at(0, m_col, 5'd0);
            if (m_col < 50) m_col++;
            tick(3);
        end
        checks++; if (max_addr !== 49) $display("FAIL sat_max_addr: got %0d want 49", max_addr); else passed++;
        checks++; if (n_rd !== 46) $display("FAIL sat_reads: got %0d want 46", n_rd); else passed++;
        checks++; if (n_frd !== 46) $display("FAIL sat_font_reads: got %0d want 46", n_frd); else passed++;
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        checks++; if (text_rd !== 1'b0) $display("FAIL sat_no_rd: got %b want 0", text_rd); else passed++;
        tick(1);
        checks++; if (font_rd !== 1'b0) $display("FAIL sat_no_frd: got %b want 0", font_rd); else passed++;
        tick(1);
        checks++; if (pixel_row !== 16'h0000) $display("FAIL sat_blank: got %h want 0000", pixel_row); else passed++;
        tick(4);
    endtask

    task automatic test_same_cycle;
        pulse(1'b1, 1'b1, 1'b0, 5'd0);
        checks++; if (text_addr !== 11'd0) $display("FAIL same_addr: got %0d want 0", text_addr); else passed++;
        tick(3);
        checks++; if (pixel_row !== 16'h0FF0) $display("FAIL same_pixel: got %h want 0ff0", pixel_row); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL same_underrun: got %b want 0", underrun); else passed++;
        tick(4);
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        checks++; if (text_addr !== 11'd2) $display("FAIL same_col: got %0d want 2", text_addr); else passed++;
        tick(2);
        checks++; if (pixel_row !== 16'h1234) $display("FAIL same_next: got %h want 1234", pixel_row); else passed++;
        tick(4);
    endtask

    task automatic test_row_advance;
        int saved;
        pulse(1'b0, 1'b1, 1'b0, 5'd5);
        checks++; if (text_addr !== 11'd0) $display("FAIL row_hold: got %0d want 0", text_addr); else passed++;
        tick(7);
        pulse(1'b0, 1'b1, 1'b0, 5'd19);
        checks++; if (text_addr !== 11'd50) $display("FAIL row1_addr: got %0d want 50", text_addr); else passed++;
        tick(3);
        checks++; if (pixel_row !== 16'h73B3) $display("FAIL row1_pixel: got %h want 73b3", pixel_row); else passed++;
        tick(4);
        pulse(1'b1, 1'b0, 1'b0, 5'd19);
        checks++; if (text_addr !== 11'd52) $display("FAIL row1_nd_addr: got %0d want 52", text_addr); else passed++;
        tick(6);
        for (int k = 0; k < 28; k++) begin
            pulse(1'b0, 1'b1, 1'b0, 5'd19);
            tick(7);
        end
        saved = n_rd;
        pulse(1'b0, 1'b1, 1'b0, 5'd19);
        checks++; if (text_rd !== 1'b0) $display("FAIL row_sat_rd: got %b want 0", text_rd); else passed++;
        tick(3);
        checks++; if (pixel_row !== 16'h0000) $display("FAIL row_sat_pixel: got %h want 0000", pixel_row); else passed++;
        tick(4);
        checks++; if (n_rd !== saved) $display("FAIL row_sat_reads: got %0d want %0d", n_rd, saved); else passed++;
        pulse(1'b0, 1'b1, 1'b1, 5'd0);
        checks++; if (text_addr !== 11'd0) $display("FAIL eof_addr: got %0d want 0", text_addr); else passed++;
        tick(3);
        checks++; if (pixel_row !== 16'h0FF0) $display("FAIL eof_pixel: got %h want 0ff0", pixel_row); else passed++;
        tick(4);
    endtask

    task automatic test_underrun;
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        tick(1);
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        checks++; if (pixel_row !== 16'h1234) $display("FAIL ur_pixel: got %h want 1234", pixel_row); else passed++;
        checks++; if (underrun !== 1'b1) $display("FAIL ur_set: got %b want 1", underrun); else passed++;
        tick(4);
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        checks++; if (text_addr !== 11'd3) $display("FAIL ur_dropped: got %0d want 3", text_addr); else passed++;
        tick(2);
        checks++; if (pixel_row !== 16'h43A0) $display("FAIL ur_seq: got %h want 43a0", pixel_row); else passed++;
        tick(14);
        checks++; if (underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", underrun); else passed++;
    endtask

    task automatic test_reset_midfetch;
        int saved;
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        resetn = 1'b0;
        #1;
        checks++; if (text_rd !== 1'b0) $display("FAIL mid_text_rd: got %b want 0", text_rd); else passed++;
        checks++; if (pixel_row !== 16'h0000 || underrun !== 1'b0)
            $display("FAIL mid_clear: got pixel=%h ur=%b want 0000/0", pixel_row, underrun); else passed++;
        saved = n_rd + n_frd;
        tick(4);
        checks++; if (n_rd + n_frd !== saved) $display("FAIL mid_no_reads: got %0d want %0d", n_rd + n_frd, saved); else passed++;
        resetn = 1'b1;
        tick(2);
    endtask

`ifdef VGA_TEXT_CURSOR_EN
    task automatic test_cursor;
        for (int k = 0; k < 32; k++) begin
            pulse(1'b0, 1'b1, 1'b1, 5'd0);
            tick(7);
        end
        pulse(1'b0, 1'b1, 1'b0, 5'd18);
        tick(7);
        pulse(1'b1, 1'b0, 1'b0, 5'd18);
        tick(6);
        pulse(1'b1, 1'b0, 1'b0, 5'd18);
        tick(6);
        pulse(1'b1, 1'b0, 1'b0, 5'd18);
        tick(2);
        checks++; if (pixel_row !== 16'hFF00) $display("FAIL cursor_invert: got %h want ff00", pixel_row); else passed++;
        tick(4);
    endtask
`endif

    initial begin
        for (int a = 0; a < 2048; a++) tram[a] = tchar(a);
        for (int a = 0; a < 8192; a++) from[a] = glyph(8'(a >> 5), 5'(a));
        tick(1);
        test_reset;
        test_line_start;
        test_newdata;
        test_col_saturation;
        test_same_cycle;
        test_row_advance;
        test_underrun;
        test_reset_midfetch;
`ifdef VGA_TEXT_CURSOR_EN
        test_cursor;
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
